// File: rtl/led_sweep_pkg.sv
// Shared types for the LED sweep sequencer: FSM state encoding and latched mode values.
package led_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/led_sweep_tick.sv
// Prescaler: one-cycle tick enable every DIV_MAX+1 enabled clk cycles; clr restarts the period.
module led_sweep_tick #(
    parameter int DIV_WIDTH = 24,
    parameter int DIV_MAX   = 1500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] LIMIT = DIV_WIDTH'(DIV_MAX);

    logic [DIV_WIDTH-1:0] cnt_reg;

    // Decoded from the registered count, so it is low whenever the counter is idle or cleared.
    assign tick = en && (cnt_reg == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (cnt_reg == LIMIT) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/led_sweep_seq.sv
// LED sweep sequencer: up/down/bounce sweeps between bounds for a programmable pass count.
// Optional LED_SWEEP_GRAY_EN drives led as the Gray code of the internal binary sweep value.
module led_sweep_seq
    import led_sweep_pkg::*;
#(
    parameter int LED_COUNT  = 4,
    parameter int DIV_WIDTH  = 24,
    parameter int DIV_MAX    = 1500000,
    parameter int LEDS_BEGIN = 0,
    parameter int LEDS_END   = 2**LED_COUNT - 1,
    parameter int LEDS_STEP  = 1,
    parameter int PASS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [PASS_WIDTH-1:0] passes,
    output logic [LED_COUNT-1:0]  led,
    output logic                  busy,
    output logic                  done,
    output logic                  tick
);

    localparam int W = LED_COUNT;
    localparam logic [W-1:0] BEGIN_V = W'(LEDS_BEGIN);
    localparam logic [W-1:0] END_V   = W'(LEDS_END);
    localparam logic [W:0]   BEGIN_X = (W+1)'(LEDS_BEGIN);
    localparam logic [W:0]   END_X   = (W+1)'(LEDS_END);
    localparam logic [W:0]   STEP_X  = (W+1)'(LEDS_STEP);

    state_t                state_reg, state_next;
    logic [W-1:0]          v_reg, v_next;
    logic [1:0]            mode_reg, mode_next;
    logic [PASS_WIDTH-1:0] passes_reg, passes_next;
    logic [PASS_WIDTH-1:0] pass_cnt_reg, pass_cnt_next;
    logic                  clr;
    logic                  pass_end;
    logic [PASS_WIDTH-1:0] last_pass;
    logic [W:0]            up_sum;
    logic [W:0]            down_diff;
    logic [W-1:0]          up_val;
    logic [W-1:0]          down_val;

    led_sweep_tick #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clr  (clr),
        .tick (tick)
    );

    assign busy = (state_reg == UP) || (state_reg == DOWN);
    assign done = (state_reg == DONE);

    // One extra bit so the clamp sees overflow/underflow instead of a wrapped value.
    assign up_sum    = {1'b0, v_reg} + STEP_X;
    assign down_diff = {1'b0, v_reg} - STEP_X;
    assign up_val    = (up_sum > END_X) ? END_V : up_sum[W-1:0];
    assign down_val  = (down_diff[W] || (down_diff < BEGIN_X)) ? BEGIN_V : down_diff[W-1:0];

    assign last_pass = (passes_reg == '0) ? '0 : passes_reg - PASS_WIDTH'(1);

    always_comb begin
        state_next    = state_reg;
        v_next        = v_reg;
        mode_next     = mode_reg;
        passes_next   = passes_reg;
        pass_cnt_next = pass_cnt_reg;
        clr           = 1'b0;
        pass_end      = 1'b0;

        if (abort) begin
            state_next = IDLE;
            v_next     = BEGIN_V;
            clr        = 1'b1;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (go) begin
                        mode_next     = mode;
                        passes_next   = passes;
                        pass_cnt_next = '0;
                        clr           = 1'b1;
                        if (mode == MODE_DOWN) begin
                            v_next     = END_V;
                            state_next = DOWN;
                        end else begin
                            v_next     = BEGIN_V;
                            state_next = UP;
                        end
                    end
                end
                UP: begin
                    if (tick) begin
                        if (v_reg != END_V) begin
                            v_next = up_val;
                        end else if (mode_reg == MODE_BOUNCE) begin
                            state_next = DOWN;
                        end else begin
                            pass_end = 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (tick) begin
                        if (v_reg != BEGIN_V) begin
                            v_next = down_val;
                        end else begin
                            pass_end = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!go) begin
                        state_next = IDLE;
                    end
                end
            endcase

            if (pass_end) begin
                if (pass_cnt_reg == last_pass) begin
                    state_next = DONE;
                    clr        = 1'b1;
                end else begin
                    pass_cnt_next = pass_cnt_reg + PASS_WIDTH'(1);
                    // Bounce ends its pass at BEGIN already, so only the plain modes reload.
                    if (mode_reg == MODE_DOWN) begin
                        v_next     = END_V;
                        state_next = DOWN;
                    end else if (mode_reg == MODE_BOUNCE) begin
                        state_next = UP;
                    end else begin
                        v_next     = BEGIN_V;
                        state_next = UP;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            v_reg        <= BEGIN_V;
            mode_reg     <= MODE_UP;
            passes_reg   <= '0;
            pass_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            v_reg        <= v_next;
            mode_reg     <= mode_next;
            passes_reg   <= passes_next;
            pass_cnt_reg <= pass_cnt_next;
        end
    end

`ifdef LED_SWEEP_GRAY_EN
    assign led = v_reg ^ (v_reg >> 1);
`else
    assign led = v_reg;
`endif

endmodule

// File: tb/tb_led_sweep_seq.sv
// Directed bench for led_sweep_seq: a sweep model queues expected post-tick states, checked after each tick.
module tb_led_sweep_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go_a = 1'b0;
    logic       go_b = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] passes = 4'd1;

    logic [3:0] led_a, led_b;
    logic       busy_a, busy_b, done_a, done_b, tick_a, tick_b;

    int total = 0;
    int bad = 0;

    typedef struct {
        int   v;
        logic busy;
        logic done;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    led_sweep_seq #(
        .LED_COUNT (4),
        .DIV_MAX   (2)
    ) dut_a (
        .clk    (clk),
        .rst    (rst),
        .go     (go_a),
        .abort  (abort),
        .mode   (mode),
        .passes (passes),
        .led    (led_a),
        .busy   (busy_a),
        .done   (done_a),
        .tick   (tick_a)
    );

    led_sweep_seq #(
        .LED_COUNT (4),
        .DIV_MAX   (2),
        .LEDS_END  (14),
        .LEDS_STEP (4)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .go     (go_b),
        .abort  (abort),
        .mode   (mode),
        .passes (passes),
        .led    (led_b),
        .busy   (busy_b),
        .done   (done_b),
        .tick   (tick_b)
    );

    function automatic logic [3:0] exp_led(input int v);
        logic [3:0] b;
        b = 4'(v);
`ifdef LED_SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v, input logic b, input logic d);
        exp_t e;
        e.v = v; e.busy = b; e.done = d;
        q.push_back(e);
    endtask

    // Expected state after every tick of a whole run, from the sweep rules.
    task automatic gen(input int md, input int np, input int lb, input int le, input int st);
        int v;
        int n;
        n = (np == 0) ? 1 : np;
        v = (md == 1) ? le : lb;
        for (int p = 0; p < n; p++) begin
            if (md != 1) begin
                while (v != le) begin
                    v = (v + st > le) ? le : v + st;
                    push(v, 1'b1, 1'b0);
                end
                if (md == 2) push(v, 1'b1, 1'b0);
            end
            if (md == 1 || md == 2) begin
                while (v != lb) begin
                    v = (v - st < lb) ? lb : v - st;
                    push(v, 1'b1, 1'b0);
                end
            end
            if (p == n - 1) begin
                push(v, 1'b0, 1'b1);
            end else begin
                if (md == 1) v = le;
                else if (md != 2) v = lb;
                push(v, 1'b1, 1'b0);
            end
        end
    endtask

    // Called at posedge+1; for each queued entry wait for tick, let the edge apply it, compare.
    task automatic drain(input bit sel, input string tag);
        exp_t e;
        int   n;
        int   waited;
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            waited = 0;
            while (((sel ? tick_b : tick_a) !== 1'b1) && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            total++;
            assert (waited < 20) else begin
                bad++;
                $error("FAIL %s_tick_timeout observed=no_tick expected=tick entry=%0d", tag, n);
                q.delete();
                break;
            end
            @(posedge clk); #1;
            check($sformatf("%s_led%0d", tag, n), sel ? led_b : led_a, exp_led(e.v));
            check($sformatf("%s_busy%0d", tag, n), sel ? busy_b : busy_a, e.busy);
            check($sformatf("%s_done%0d", tag, n), sel ? done_b : done_a, e.done);
            n++;
        end
        $display("transaction %s: %0d ticks checked", tag, n);
    endtask

    task automatic start(input bit sel, input logic [1:0] md, input logic [3:0] np);
        @(negedge clk);
        mode = md;
        passes = np;
        if (sel) go_b = 1'b1; else go_a = 1'b1;
        @(posedge clk); #1;
        go_a = 1'b0;
        go_b = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  found;

        // Reset state
        #2;
        check("rst_led", led_a, exp_led(0));
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_tick", tick_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Up, one pass; mode/passes changed while busy must be ignored
        gen(0, 1, 0, 15, 1);
        start(1'b0, 2'b00, 4'd1);
        check("up_start_busy", busy_a, 1);
        mode = 2'b01;
        passes = 4'd5;
        drain(1'b0, "up");
        @(posedge clk); #1;
        check("up_idle_done", done_a, 0);
        check("up_idle_busy", busy_a, 0);
        check("up_idle_led", led_a, exp_led(15));

        // Bounce, two passes
        gen(2, 2, 0, 15, 1);
        start(1'b0, 2'b10, 4'd2);
        drain(1'b0, "bounce");
        @(posedge clk); #1;
        check("bounce_idle_done", done_a, 0);

        // Down, three passes
        gen(1, 3, 0, 15, 1);
        start(1'b0, 2'b01, 4'd3);
        check("down_start_led", led_a, exp_led(15));
        drain(1'b0, "down");
        @(posedge clk); #1;

        // Reserved mode behaves as up
        gen(0, 1, 0, 15, 1);
        start(1'b0, 2'b11, 4'd1);
        drain(1'b0, "reserved");
        @(posedge clk); #1;

        // Step 4, end 14: clamped final step
        gen(0, 1, 0, 14, 4);
        start(1'b1, 2'b00, 4'd1);
        check("step_a_idle", busy_a, 0);
        drain(1'b1, "step");
        @(posedge clk); #1;
        check("step_idle_done", done_b, 0);

        // Abort at led=7 in the same cycle as tick
        start(1'b0, 2'b00, 4'd1);
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < 200) begin
            if (led_a === exp_led(7) && tick_a === 1'b1) found = 1'b1;
            else begin @(posedge clk); #1; cnt++; end
        end
        check("abort_found", found, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_led", led_a, exp_led(0));
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_tick", tick_a, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_stays_idle", busy_a, 0);
        $display("transaction abort: led=%0d busy=%0b", led_a, busy_a);

        // passes=0 with go held high: one pass, then no restart until go toggles
        gen(0, 0, 0, 15, 1);
        @(negedge clk);
        mode = 2'b00;
        passes = 4'd0;
        go_a = 1'b1;
        @(posedge clk); #1;
        drain(1'b0, "hold");
        repeat (10) @(posedge clk);
        #1;
        check("hold_done", done_a, 1);
        check("hold_busy", busy_a, 0);
        check("hold_led", led_a, exp_led(15));
        @(negedge clk);
        go_a = 1'b0;
        @(posedge clk); #1;
        check("hold_release_done", done_a, 0);
        check("hold_release_busy", busy_a, 0);
        @(negedge clk);
        go_a = 1'b1;
        @(posedge clk); #1;
        go_a = 1'b0;
        check("hold_restart_busy", busy_a, 1);
        check("hold_restart_led", led_a, exp_led(0));
        $display("transaction hold: restart busy=%0b", busy_a);

        // Asynchronous reset mid-sweep
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_led", led_a, exp_led(0));
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_tick", tick_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_after_busy", busy_a, 0);
        check("arst_after_tick", tick_a, 0);
        $display("transaction async_reset: led=%0d busy=%0b", led_a, busy_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
